mem_req_queue: RTL

//  Ingress stage in front of the DRAM command scheduler.
//  - Accepts timestamped CPU requests (op, 36-bit address).
//  - Holds each request until its arrival time is reached, then pushes it into a 16-entry in-order queue.
//  - Presents the head entry to the scheduler with address fields already decoded.
//  - Asserts full to stall the CPU side; drops malformed requests and flags them.

---
 rtl/mem_req_queue.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_req_queue.sv
// mem_req_queue: ingress stage in front of the DRAM command scheduler.
// A request is held in a one-entry stage until the free-running cycle counter
// reaches its timestamp. It then moves into an in-order queue, and the head
// entry is shown with its DRAM address fields already decoded. Illegal ops and
// addresses with bit 6 set are dropped, and a one-cycle error flag reports the drop.
module mem_req_queue #(
  parameter int DEPTH  = 16,   // power of two, >= 2
  parameter int ADDR_W = 36,   // must be > 34 (row field tops out at bit 33)
  parameter int TIME_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  // CPU side
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TIME_W-1:0]            in_time,
  input  logic [1:0]                   in_op,
  input  logic [ADDR_W-1:0]            in_addr,
  // scheduler side
  output logic                         out_valid,
  output logic [1:0]                   out_op,
  output logic [15:0]                  out_row,
  output logic [9:0]                   out_col,
  output logic [1:0]                   out_bank,
  output logic [2:0]                   out_bg,
  output logic                         out_chan,
  input  logic                         out_pop,
  // status
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         q_full,
  output logic                         err_pulse,
  output logic [TIME_W-1:0]            cyc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_IFETCH  = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  // Entries are stored already decoded. The scheduler only needs the fields,
  // so decoding once at the stage keeps the head path short.
  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] row;
    logic [9:0]  col;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        chan;
  } entry_t;

  // Staging register
  logic              stage_v;
  logic [TIME_W-1:0] stage_time;
  entry_t            stage_entry;
  entry_t            in_entry;

  // Queue storage and bookkeeping
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  entry_t            head;
  entry_t            held;
  entry_t            shown;

  // Handshake terms
  logic accept;
  logic malformed;
  logic enq;
  logic pop;
  logic full;

  // Address bits that carry no DRAM coordinate: byte offset and the top bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_addr[ADDR_W-1:34], in_addr[1:0]};

  // Field decode of the incoming address
  assign in_entry = '{
    op:   in_op,
    row:  in_addr[33:18],
    col:  {in_addr[17:12], in_addr[5:2]},
    bank: in_addr[11:10],
    bg:   in_addr[9:7],
    chan: in_addr[6]
  };

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_pop && out_valid;
  // A full queue accepts the stage only when the head retires this same edge.
  // This is the only path from out_pop to in_ready.
  assign enq       = stage_v && (cyc >= stage_time) && (!full || pop);
  assign in_ready  = !stage_v || enq;
  assign accept    = in_valid && in_ready;
  assign malformed = (in_op == OP_ILLEGAL) || in_addr[6];

  assign q_count = count;
  assign q_full  = full;

  // Free-running cycle counter; wraps naturally at 2^TIME_W.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + TIME_W'(1);
  end

  // Stage load/clear. A well-formed accept always wins, so a new request can
  // replace the one leaving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_v     <= 1'b0;
      stage_time  <= '0;
      stage_entry <= '0;
    end else if (accept && !malformed) begin
      stage_v     <= 1'b1;
      stage_time  <= in_time;
      stage_entry <= in_entry;
    end else if (enq) begin
      stage_v     <= 1'b0;
    end
  end

  // Drop report for malformed requests, visible the cycle after the accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_pulse <= 1'b0;
    else     err_pulse <= accept && malformed;
  end

  // Queue storage write.
  // NOTE: the array has no reset. Every slot is written before count can make
  // it visible, so clearing the pointers and count is enough.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= stage_entry;
  end

  // Pointers wrap modulo DEPTH by width, since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged, including when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Remember the last head shown, so the outputs hold steady while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            held <= '0;
    else if (out_valid) held <= head;
  end

  // Head field select: the live head when non-empty, otherwise the last head shown.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    shown = held;
    if (out_valid) shown = head;
  end

  assign out_op   = shown.op;
  assign out_row  = shown.row;
  assign out_col  = shown.col;
  assign out_bank = shown.bank;
  assign out_bg   = shown.bg;
  assign out_chan = shown.chan;

endmodule
